// File: rtl/vecmat_sched.sv
// Sequencing controller for the vecmat_mul datapath: loads a Q vector, streams K rows,
// and tags each datapath product with a valid strobe and row index.
module vecmat_sched #(
    parameter int unsigned NUM_WORDS = 32,
    parameter int unsigned AWIDTH    = 5,
    parameter int unsigned MEM_LAT   = 1,
    parameter int unsigned MUL_LAT   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [AWIDTH:0]   num_rows,
    input  logic [AWIDTH-1:0] q_base,
    input  logic              pause,
    output logic              q_rd_en,
    output logic [AWIDTH-1:0] q_rd_addr,
    output logic              q_load,
    output logic              k_rd_en,
    output logic [AWIDTH-1:0] k_rd_addr,
    output logic              out_valid,
    output logic [AWIDTH-1:0] out_idx,
    output logic              busy,
    output logic              done
);

    localparam int unsigned     PIPE     = MEM_LAT + MUL_LAT;
    localparam logic [AWIDTH:0] MAX_ROWS = (AWIDTH + 1)'(NUM_WORDS);
    localparam logic [AWIDTH:0] ONE      = (AWIDTH + 1)'(1);

    typedef enum logic [2:0] {
        StIdle,
        StQrd,
        StQld,
        StIssue,
        StDrain,
        StDone
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AWIDTH:0]   r_rows;
    logic [AWIDTH:0]   r_cnt;
    logic [AWIDTH-1:0] r_qbase;
    logic [PIPE-1:0]   r_vld;
    logic [AWIDTH-1:0] r_idx [PIPE];
    logic [AWIDTH:0]   w_rows_clamped;
    logic              w_issue;
    logic              w_last;

    assign w_rows_clamped = (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;
    assign w_issue        = (r_state == StIssue) && !pause;
    assign w_last         = w_issue && (r_cnt == (r_rows - ONE));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        q_rd_en     = 1'b0;
        q_rd_addr   = '0;
        q_load      = 1'b0;
        k_rd_en     = 1'b0;
        k_rd_addr   = '0;
        busy        = 1'b1;
        done        = 1'b0;
        unique case (r_state)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = (w_rows_clamped == '0) ? StDone : StQrd;
                end
            end
            StQrd: begin
                q_rd_en     = 1'b1;
                q_rd_addr   = r_qbase;
                w_state_nxt = StQld;
            end
            StQld: begin
                q_load      = 1'b1;
                w_state_nxt = StIssue;
            end
            StIssue: begin
                k_rd_en   = w_issue;
                k_rd_addr = w_issue ? r_cnt[AWIDTH-1:0] : '0;
                if (w_last) begin
                    w_state_nxt = StDrain;
                end
            end
            StDrain: begin
                if (r_vld == '0) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                done        = 1'b1;
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Tag pipeline mirrors the read + multiply latency and never stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rows  <= '0;
            r_qbase <= '0;
            r_cnt   <= '0;
            r_vld   <= '0;
            for (int i = 0; i < PIPE; i++) begin
                r_idx[i] <= '0;
            end
        end else begin
            if ((r_state == StIdle) && start) begin
                r_rows  <= w_rows_clamped;
                r_qbase <= q_base;
            end
            if (r_state == StQld) begin
                r_cnt <= '0;
            end else if (w_issue) begin
                r_cnt <= r_cnt + ONE;
            end
            r_vld    <= {r_vld[PIPE-2:0], w_issue};
            r_idx[0] <= w_issue ? r_cnt[AWIDTH-1:0] : '0;
            for (int i = 1; i < PIPE; i++) begin
                r_idx[i] <= r_idx[i-1];
            end
        end
    end

    assign out_valid = r_vld[PIPE-1];
    assign out_idx   = r_idx[PIPE-1];

endmodule

// File: doc/vecmat_sched.md
# vecmat_sched

Sequencing controller for the 64-lane element-wise multiply datapath (`vecmat_mul`, 2-cycle latency, no enable) in the attention layer. On `start`, it latches a Q vector, then streams K-matrix rows from a 1-cycle-latency read port into the datapath, one row per cycle. It tags each product leaving the datapath with a valid strobe and a row index, supports an issue-side `pause`, and signals completion with `done`.

## Interface
Parameters:
- `NUM_WORDS`, default 32: maximum rows per pass.
- `AWIDTH`, default 5: row address width; must satisfy 2^AWIDTH ≥ NUM_WORDS.
- `MEM_LAT`, default 1: K/Q memory read latency in cycles. Fixed at 1.
- `MUL_LAT`, default 2: datapath latency from input to `tmp`. Fixed at 2.

Ports:
- `clk`, in, 1: single clock; all logic on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begin a pass. Sampled only in IDLE.
- `num_rows`, in, AWIDTH+1: number of K rows for this pass. Sampled with `start`. Values above NUM_WORDS are clamped to NUM_WORDS.
- `q_base`, in, AWIDTH: Q memory address. Sampled with `start`.
- `pause`, in, 1: when high, no new K read is issued. Reads already in flight complete.
- `q_rd_en`, out, 1: Q memory read strobe.
- `q_rd_addr`, out, AWIDTH: Q memory read address.
- `q_load`, out, 1: load Q read data into the vector register feeding `vector`.
- `k_rd_en`, out, 1: K memory read strobe.
- `k_rd_addr`, out, AWIDTH: K row address.
- `out_valid`, out, 1: `tmp` holds a product this cycle.
- `out_idx`, out, AWIDTH: row index of the current `tmp`.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse at end of pass.

## Operation
States:
- **IDLE**
  - `start`=1 with clamped `num_rows`=0: go to DONE.
  - `start`=1 otherwise: latch `num_rows` and `q_base`, go to QRD.
  - `start` is ignored in every other state.
- **QRD**: assert `q_rd_en`, drive `q_rd_addr`=`q_base`; go to QLD.
- **QLD**: assert `q_load` (read data valid this cycle); clear the issue counter; go to ISSUE.
- **ISSUE**
  - Each cycle with `pause`=0: assert `k_rd_en`, drive `k_rd_addr`=issue counter, push (valid=1, idx=counter) into the tag pipeline, increment the counter.
  - Each cycle with `pause`=1: `k_rd_en`=0 and a bubble (valid=0) is pushed.
  - After the cycle that issues row `num_rows`-1, go to DRAIN.
- **DRAIN**: push bubbles. Stay until the tag pipeline holds no valid entry, then go to DONE.
- **DONE**: `done`=1 for one cycle; go to IDLE.

Tag pipeline:
- Depth MEM_LAT+MUL_LAT = 3 stages. Stage 3 drives `out_valid`/`out_idx`.
- It shifts every cycle, in all states, because the datapath cannot stall.
- Output is not gated by `pause`.

Other rules:
- The issue counter is AWIDTH+1 bits. It never wraps within a pass, since the clamped count is ≤ NUM_WORDS.
- `pause` asserted in QRD/QLD has no effect; Q is always loaded.

## Timing
- Reset values (cycle after `reset`=1):
  - state = IDLE.
  - `busy`, `done`, `q_rd_en`, `q_load`, `k_rd_en`, `out_valid` = 0.
  - `k_rd_addr`, `q_rd_addr`, `out_idx` = 0.
  - All tag stages invalid.
- Reset mid-pass aborts the pass: no `done`, and in-flight tags are discarded (`out_valid`=0 from the next cycle).
- `start` at cycle T:
  - QRD at T+1.
  - QLD at T+2.
  - First `k_rd_en` at T+3.
- A K read issued at cycle t produces `out_valid`=1 with `out_idx`=that address at cycle t+3.
- With no pause, N rows give `out_valid` at T+6 … T+5+N.
  - `done` at T+7+N: DRAIN ends once the final result has left stage 3, then DONE.
- Pause cycles delay each later result one-for-one. Gaps appear in `out_valid` at the same spacing.
- `num_rows`=0: `busy`=1 at T+1 (state DONE), `done` at T+1, back in IDLE at T+2. No memory reads occur.
- `busy` is high from T+1 through the `done` cycle inclusive.
- A new `start` is accepted in the cycle after `done`; back-to-back passes lose one cycle.

## Test plan
- **Basic pass**: reset, `num_rows`=4, `q_base`=7, `start` at T.
  - Expect `q_rd_addr`=7 at T+1 and `q_load` at T+2.
  - Expect `k_rd_addr` 0,1,2,3 at T+3..T+6.
  - Expect `out_valid` with `out_idx` 0..3 at T+6..T+9, and `done` at T+11.
  - End-to-end check against the real datapath: rows of `matrix` 0x1000 (1.0 in Q4.12) with `vector` 0x2000 give `tmp` lanes 0x2000.
- **Pause**: `num_rows`=3, `pause`=1 only at T+4.
  - Expect `k_rd_addr` 0 at T+3 and 1,2 at T+5,T+6.
  - Expect `out_idx` 0 at T+6 and 1,2 at T+8,T+9; `out_valid`=0 at T+7.
- **Clamp and zero**:
  - `num_rows`=40 → exactly 32 `out_valid` pulses, last `out_idx`=31.
  - `num_rows`=0 → `done` at T+1, no `k_rd_en` or `q_rd_en`.
- **Reset mid-pass**: `num_rows`=8, `reset` at T+5.
  - Expect all outputs 0 from T+6 and no `done`.
  - A new `start` at T+8 runs a full, correct pass.
- **Start while busy**: pulse `start` at T+4 with `num_rows`=2 during a 4-row pass.
  - Expect it ignored: 4 results and a single `done`.
- **Back-to-back passes**: `start` in the cycle after `done`.
  - Expect the second pass's first `k_rd_en` 3 cycles later.
  - Expect no overlap of `out_valid` between the two passes.
